// File: rtl/fir_axis_sink.sv
// AXI-Stream sink for FIR results: round-half-up rescale, saturate to 16-bit signed, buffer in a FIFO.
// Also keeps debug counters for accepted and saturated samples.
module fir_axis_sink #(
    parameter int SHIFT = 15,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_data_tvalid,
    input  logic [31:0]              s_axis_data_tdata,
    output logic                     s_axis_data_tready,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [15:0]              rd_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         sat_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [32:0] RND  = (SHIFT > 0) ? (33'sd1 <<< RND_SH) : 33'sd0;
    localparam logic signed [32:0] MAXV = 33'sd32767;
    localparam logic signed [32:0] MINV = -33'sd32768;

    logic              rst_q;
    logic [15:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_nxt;
    logic              push, pop, sat;
    logic signed [32:0] ext, sum, r;
    logic [15:0]       res;

    // rst_q keeps tready low for one cycle after reset release
    assign s_axis_data_tready = rst_q & ~fifo_full;
    assign push = s_axis_data_tvalid & s_axis_data_tready;
    assign pop  = rd_en & ~fifo_empty;

    always_comb begin
        ext = {s_axis_data_tdata[31], s_axis_data_tdata};
        sum = ext + RND;
        r   = sum >>> SHIFT;
        sat = 1'b1;
        if (r > MAXV)
            res = 16'h7FFF;
        else if (r < MINV)
            res = 16'h8000;
        else begin
            res = r[15:0];
            sat = 1'b0;
        end
    end

    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop)
            level_nxt = fifo_level + 1'b1;
        else if (pop && !push)
            level_nxt = fifo_level - 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rst_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            sample_cnt <= '0;
            sat_cnt    <= '0;
        end else begin
            rst_q    <= 1'b1;
            rd_valid <= pop;
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                sample_cnt <= sample_cnt + 1'b1;
                if (sat && !(&sat_cnt))
                    sat_cnt <= sat_cnt + 1'b1;
            end
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            fifo_level <= level_nxt;
            fifo_empty <= (level_nxt == '0);
            fifo_full  <= (level_nxt == LW'(DEPTH));
        end
    end

    // Storage is not reset; emptiness is tracked by the level alone
    always_ff @(posedge aclk) begin
        if (aresetn && push)
            mem[wr_ptr] <= res;
    end
endmodule

// File: tb/tb_fir_axis_sink.sv
// Directed bench for fir_axis_sink: scoreboard of expected read data, immediate-assert checks.
module tb_fir_axis_sink;
    localparam int SHIFT = 15;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = '0;
    logic        tready;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        fifo_empty, fifo_full;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0] sample_cnt, sat_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rd     = 0;
    int n_acc    = 0;
    logic [15:0] sb[$];

    fir_axis_sink #(.SHIFT(SHIFT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_data_tvalid(tvalid), .s_axis_data_tdata(tdata), .s_axis_data_tready(tready),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .sample_cnt(sample_cnt), .sat_cnt(sat_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit integer rounding then clamp
    function automatic logic [15:0] model(input logic [31:0] d);
        longint v, q;
        v = longint'($signed(d));
        q = (SHIFT > 0) ? ((v + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT) : v;
        if (q > 32767) return 16'h7FFF;
        if (q < -32768) return 16'h8000;
        return q[15:0];
    endfunction

    function automatic logic [31:0] rnd_sample();
        int s;
        s = int'($urandom);
        return 32'(s >>> $urandom_range(0, 18));
    endfunction

    // One clock: drive inputs, log acceptance at the falling edge, return 1ns after the rising edge
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic [15:0] exp);
        tvalid = v; tdata = d; rd_en = r;
        @(negedge aclk);
        if (aresetn && v && tready) begin
            sb.push_back(exp);
            n_acc++;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 16'h0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 16'h0);
        idle(1);
    endtask

    task automatic do_reset(input int n);
        aresetn = 1'b0;
        for (int i = 0; i < n; i++) step(1'b1, 32'h1234_5678, 1'b0, 16'h0);
        sb.delete();
        aresetn = 1'b1;
        tvalid = 1'b0;
    endtask

    always @(negedge aclk) begin
        if (aresetn && rd_valid === 1'b1) begin
            n_rd++;
            if (sb.size() == 0)
                chk("rd_unexpected", 32'(rd_data), 32'hDEAD_0000);
            else
                chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        // Reset held with tvalid asserted
        do_reset(3);
        chk("rst_tready_first", 32'(tready), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        idle(1);
        chk("tready_after_rst", 32'(tready), 32'd1);

        // Rounding
        step(1'b1, 32'h0000_4000, 1'b0, 16'h0001);
        chk("empty_after_push", 32'(fifo_empty), 32'd0);
        step(1'b1, 32'h0000_3FFF, 1'b0, 16'h0000);
        step(1'b1, 32'hFFFF_C000, 1'b0, 16'h0000);
        step(1'b1, 32'hFFFF_BFFF, 1'b0, 16'hFFFF);
        idle(1);
        chk("round_level", 32'(fifo_level), 32'd4);
        chk("round_sample_cnt", 32'(sample_cnt), 32'd4);
        chk("round_sat_cnt", 32'(sat_cnt), 32'd0);
        drain(4);
        chk("round_sb_empty", 32'(sb.size()), 32'd0);
        chk("round_n_rd", 32'(n_rd), 32'd4);

        // Pop while empty: no pulse, data held
        step(1'b0, 32'h0, 1'b1, 16'h0);
        chk("empty_pop_valid", 32'(rd_valid), 32'd0);
        chk("empty_pop_hold", 32'(rd_data), 32'h0000_FFFF);
        chk("empty_pop_level", 32'(fifo_level), 32'd0);

        // Saturation (0x3FFFC000 rounds to exactly 32768, so it clamps too)
        step(1'b1, 32'h7FFF_FFFF, 1'b0, 16'h7FFF);
        step(1'b1, 32'h8000_0000, 1'b0, 16'h8000);
        step(1'b1, 32'h3FFF_C000, 1'b0, 16'h7FFF);
        idle(1);
        chk("sat_sat_cnt", 32'(sat_cnt), 32'd3);
        chk("sat_sample_cnt", 32'(sample_cnt), 32'd7);
        drain(3);
        chk("sat_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure from a fresh reset
        do_reset(2);
        idle(1);
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            d = rnd_sample();
            step(1'b1, d, 1'b0, model(d));
        end
        chk("bp_accepted", 32'(n_acc), 32'd16);
        chk("bp_full", 32'(fifo_full), 32'd1);
        chk("bp_tready", 32'(tready), 32'd0);
        chk("bp_level", 32'(fifo_level), 32'd16);
        chk("bp_sample_cnt", 32'(sample_cnt), 32'd16);
        d = rnd_sample();
        step(1'b1, d, 1'b1, model(d));
        chk("bp_no_push_when_full", 32'(n_acc), 32'd16);
        chk("bp_tready_after_pop", 32'(tready), 32'd1);
        chk("bp_level_after_pop", 32'(fifo_level), 32'd15);
        d = rnd_sample();
        step(1'b1, d, 1'b0, model(d));
        chk("bp_17th", 32'(n_acc), 32'd17);
        chk("bp_sample_cnt17", 32'(sample_cnt), 32'd17);
        chk("bp_full_again", 32'(fifo_full), 32'd1);
        drain(16);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        chk("bp_empty", 32'(fifo_empty), 32'd1);

        // Concurrent push/pop at half full
        do_reset(2);
        idle(1);
        for (int i = 0; i < DEPTH / 2; i++) begin
            d = rnd_sample();
            step(1'b1, d, 1'b0, model(d));
        end
        chk("conc_fill_level", 32'(fifo_level), 32'(DEPTH / 2));
        n_rd = 0;
        for (int i = 0; i < 100; i++) begin
            d = rnd_sample();
            step(1'b1, d, 1'b1, model(d));
            chk("conc_level", 32'(fifo_level), 32'(DEPTH / 2));
        end
        drain(DEPTH / 2);
        chk("conc_sb_empty", 32'(sb.size()), 32'd0);
        chk("conc_n_rd", 32'(n_rd), 32'(100 + DEPTH / 2));
        step(1'b0, 32'h0, 1'b1, 16'h0);
        chk("conc_empty_pop", 32'(rd_valid), 32'd0);

        // Reset mid-stream with 5 entries
        for (int i = 0; i < 5; i++) begin
            d = rnd_sample();
            step(1'b1, d, 1'b0, model(d));
        end
        chk("mid_level5", 32'(fifo_level), 32'd5);
        do_reset(2);
        chk("mid_empty", 32'(fifo_empty), 32'd1);
        chk("mid_level", 32'(fifo_level), 32'd0);
        chk("mid_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("mid_sat_cnt", 32'(sat_cnt), 32'd0);
        step(1'b0, 32'h0, 1'b1, 16'h0);
        chk("mid_pop1", 32'(rd_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1, 16'h0);
        chk("mid_pop2", 32'(rd_valid), 32'd0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
